// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in
// over a programmable window of clk cycles.
module freq_meter #(
    parameter int CNT_W  = 32,
    parameter int GATE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              cnt_valid,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic edge_p;

    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              ovf_int_q, ovf_int_d;
    logic [GATE_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_p = s2_q & ~s3_q;

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        ovf_int_d  = ovf_int_q;
        timer_d    = timer_q;
        cnt_out_d  = cnt_out_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    timer_d    = (gate_len == '0) ? GATE_W'(1) : gate_len;
                    edge_cnt_d = '0;
                    ovf_int_d  = 1'b0;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                // Saturate instead of wrapping so a fast input reads as max.
                if (edge_p) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_int_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                timer_d = timer_q - GATE_W'(1);
                if (timer_q == GATE_W'(1)) begin
                    cnt_out_d = edge_cnt_d;
                    ovf_d     = ovf_int_d;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            ovf_int_q  <= 1'b0;
            timer_q    <= '0;
            cnt_out_q  <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_int_q  <= ovf_int_d;
            timer_q    <= timer_d;
            cnt_out_q  <= cnt_out_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed scenarios plus randomized runs
// checked each cycle against a window-counting reference model.
module tb_freq_meter;

    localparam int CW   = 4;
    localparam int GW   = 8;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sig_in;
    logic          start = 1'b0;
    logic [GW-1:0] gate_len = '0;
    logic          busy;
    logic [CW-1:0] cnt_out;
    logic          cnt_valid;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    freq_meter #(
        .CNT_W (CW),
        .GATE_W(GW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .gate_len (gate_len),
        .start    (start),
        .busy     (busy),
        .cnt_out  (cnt_out),
        .cnt_valid(cnt_valid),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Signal source: 0 manual, 1 square wave, 2 constant high, 3 random bits
    int   sig_mode = 0;
    int   sig_per  = 8;
    logic sig_man  = 1'b0;
    logic sig_gen  = 1'b0;
    int   ph       = 0;

    assign sig_in = (sig_mode == 0) ? sig_man : sig_gen;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            case (sig_mode)
                1: begin
                    ph      = (ph + 1) % sig_per;
                    sig_gen = ((ph % sig_per) < sig_per / 2);
                end
                2: sig_gen = 1'b1;
                3: sig_gen = 1'($urandom_range(0, 1));
                default: sig_gen = 1'b0;
            endcase
        end
    end

    // Reference model: sig history, window bookkeeping, expected outputs
    logic [3:0] hv = '0;
    int   phase = 0;
    int   rem = 0;
    int   cnt_m = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    logic exp_busy = 1'b0;
    logic exp_valid = 1'b0;
    logic exp_ovf = 1'b0;

    always @(posedge clk) begin
        logic p;
        cyc++;
        if (!rst) begin
            hv        = '0;
            phase     = 0;
            exp_cnt   = 0;
            exp_ovf   = 1'b0;
            exp_valid = 1'b0;
        end else begin
            hv        = {hv[2:0], sig_in};
            p         = hv[2] & ~hv[3];
            exp_valid = 1'b0;
            case (phase)
                1: begin
                    cnt_m += int'(p);
                    rem--;
                    if (rem == 0) begin
                        phase     = 2;
                        exp_cnt   = (cnt_m > MAXC) ? MAXC : cnt_m;
                        exp_ovf   = (cnt_m > MAXC);
                        exp_valid = 1'b1;
                    end
                end
                2: phase = 0;
                default: begin
                    if (start) begin
                        rem   = (gate_len == 0) ? 1 : int'(gate_len);
                        cnt_m = 0;
                        phase = 1;
                    end
                end
            endcase
        end
        exp_busy = (phase != 0);
        #1;
        checks++;
        if (busy !== exp_busy || cnt_valid !== exp_valid ||
            int'(cnt_out) != exp_cnt || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL model cyc %0d got busy=%0b valid=%0b cnt=%0d ovf=%0b want busy=%0b valid=%0b cnt=%0d ovf=%0b",
                     cyc, busy, cnt_valid, cnt_out, ovf,
                     exp_busy, exp_valid, exp_cnt, exp_ovf);
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic pulse_start(input int g);
        gate_len = GW'(g);
        start    = 1'b1;
        cyc1();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int maxc, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        while (!found && n < maxc) begin
            n++;
            if (cnt_valid) found = 1'b1;
            else cyc1();
        end
        if (!found) begin
            chk({name, "_timeout"}, 0, 1);
            n = -1;
        end
    endtask

    initial begin
        int n;
        int nb;
        int nv;

        repeat (3) cyc1();
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_valid", int'(cnt_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b1;
        repeat (2) cyc1();

        sig_mode = 1;
        sig_per  = 8;
        repeat (5) cyc1();
        pulse_start(80);
        wait_valid("p8", 200, n);
        chk("p8_latency", n, 81);
        chk("p8_cnt", int'(cnt_out), 10);
        chk("p8_ovf", int'(ovf), 0);
        repeat (2) cyc1();

        sig_mode = 2;
        repeat (5) cyc1();
        pulse_start(50);
        nb = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            nb++;
            cyc1();
        end
        chk("const_busy_len", nb, 51);
        chk("const_cnt", int'(cnt_out), 0);
        chk("const_ovf", int'(ovf), 0);

        sig_mode = 1;
        sig_per  = 2;
        repeat (4) cyc1();
        pulse_start(64);
        wait_valid("sat", 200, n);
        chk("sat_cnt", int'(cnt_out), 15);
        chk("sat_ovf", int'(ovf), 1);
        repeat (2) cyc1();
        sig_per = 16;
        repeat (4) cyc1();
        pulse_start(64);
        wait_valid("p16", 200, n);
        chk("p16_cnt", int'(cnt_out), 4);
        chk("p16_ovf", int'(ovf), 0);
        repeat (2) cyc1();

        sig_mode = 0;
        sig_man  = 1'b0;
        repeat (4) cyc1();
        sig_man = 1'b1;
        cyc1();
        pulse_start(0);
        wait_valid("g0", 20, n);
        chk("g0_latency", n, 2);
        chk("g0_cnt", int'(cnt_out), 1);
        sig_man = 1'b0;
        repeat (2) cyc1();

        sig_mode = 1;
        sig_per  = 6;
        repeat (2) cyc1();
        pulse_start(20);
        repeat (5) cyc1();
        pulse_start(3);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_valid) begin
                nv++;
                cyc1();
                chk("busy_after_done", int'(busy), 0);
            end else begin
                cyc1();
            end
        end
        chk("one_valid", nv, 1);

        sig_per = 8;
        pulse_start(100);
        repeat (49) cyc1();
        rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(cnt_out), 0);
        chk("abort_valid", int'(cnt_valid), 0);
        chk("abort_ovf", int'(ovf), 0);
        repeat (3) cyc1();
        rst = 1'b1;
        nv  = 0;
        for (int i = 0; i < 110; i++) begin
            if (cnt_valid) nv++;
            cyc1();
        end
        chk("no_valid_after_abort", nv, 0);
        pulse_start(40);
        wait_valid("post_rst", 100, n);
        chk("post_rst_latency", n, 41);
        chk("post_rst_cnt", int'(cnt_out), 5);
        repeat (2) cyc1();

        for (int r = 0; r < 40; r++) begin
            int g;
            sig_mode = int'($urandom_range(1, 3));
            sig_per  = 2 * int'($urandom_range(1, 6));
            g        = int'($urandom_range(0, 40));
            repeat ($urandom_range(0, 5)) cyc1();
            pulse_start(g);
            for (int i = 0; i < g + 5; i++) begin
                start    = ($urandom_range(0, 7) == 0);
                gate_len = GW'($urandom_range(0, 30));
                if ($urandom_range(0, 149) == 0) rst = 1'b0;
                cyc1();
                rst = 1'b1;
            end
            start = 1'b0;
        end
        repeat (60) cyc1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of the edge counter and cnt_out.
REQ-002 Parameter GATE_W, default 32, width of gate_len and the internal gate timer.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately, regardless of clk.
REQ-005 sig_in  input  1  signal to measure, asynchronous to clk (e.g. a ripple-divider tap).
REQ-006 gate_len  input  GATE_W  measurement window length in clk cycles, sampled on an accepted start.
REQ-007 start  input  1  single-cycle request to begin a measurement.
REQ-008 busy  output  1  high while a measurement is in progress (states MEASURE and DONE).
REQ-009 cnt_out  output  CNT_W  rising-edge count of the last completed measurement.
REQ-010 cnt_valid  output  1  one-cycle pulse when cnt_out is updated.
REQ-011 ovf  output  1  the last completed measurement saturated its counter.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer (s1, s2), then a third flop s3; edge pulse = s2 & ~s3.
REQ-013 A rising edge on sig_in produces exactly one edge pulse, 3 clk edges later; no pulse on falling edges.
REQ-014 FSM states SHALL be IDLE, MEASURE and DONE; reset state is IDLE.
REQ-015 IDLE: start=1 at cycle T latches the window G = max(gate_len,1), clears the edge counter and ovf_int, and goes to MEASURE at T+1.
REQ-016 MEASURE occupies exactly cycles T+1..T+G; the gate timer counts down from G, and the last MEASURE cycle is the one where timer==1.
REQ-017 Each edge pulse in a MEASURE cycle increments the edge counter by 1; pulses outside MEASURE are ignored.
REQ-018 If the edge counter is at 2^CNT_W-1 and an edge pulse arrives, the counter holds (saturates) and ovf_int is set.
REQ-019 DONE (cycle T+G+1): cnt_out <= the edge count including any edge in cycle T+G, ovf <= ovf_int, cnt_valid=1 for that cycle only; next state IDLE.
REQ-020 cnt_out and ovf hold their values until the next DONE.
REQ-021 start during MEASURE or DONE is ignored and not queued; start in the same cycle DONE returns to IDLE is ignored; start is accepted from the following cycle.
REQ-022 busy=1 in MEASURE and DONE, 0 in IDLE; start with gate_len=0 behaves as gate_len=1.
REQ-023 The maximum measurable edge rate is clk/2; faster sig_in is out of scope and its count is unspecified.

Reset
REQ-024 While rst=0: state=IDLE, s1=s2=s3=0, edge counter=0, gate timer=0, cnt_out=0, cnt_valid=0, ovf=0, busy=0.
REQ-025 Reset asserted mid-MEASURE aborts the measurement; no cnt_valid is produced for it.
REQ-026 After rst rises, a sig_in that is already high yields one edge pulse 3 cycles later; the pulse is counted only if a measurement is active.

Verification
REQ-027 sig_in period 8 clk (high 4, low 4), start with gate_len=80 -> cnt_valid exactly 81 cycles after start, cnt_out=10, ovf=0.
REQ-028 sig_in held constant at 1 since before start, gate_len=50 -> cnt_out=0, ovf=0, busy high for 51 cycles.
REQ-029 CNT_W=4, sig_in period 2 clk, gate_len=64 -> cnt_out=15, ovf=1; a following run with sig_in period 16 and gate_len=64 -> cnt_out=4, ovf=0.
REQ-030 gate_len=0 with a single sig_in rise whose pulse lands in cycle T+1 -> MEASURE lasts 1 cycle, cnt_out=1, cnt_valid at T+2.
REQ-031 Second start pulsed during MEASURE -> ignored: exactly one cnt_valid, and busy falls after it.
REQ-032 rst pulled low halfway through gate_len=100 -> all outputs are 0 at once, no cnt_valid; a new start after release measures normally.
